// File: rtl/sram_wb_arbiter.sv
// rtl/sram_wb_arbiter.sv - two-master wishbone arbiter in front of the SPI SRAM port
// Alternates ibus/dbus on contention and holds one idle GAP cycle after every completion.
module sram_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_cyc,
  input  logic [13:0] ibus_adr,
  output logic [31:0] ibus_dat_o,
  output logic        ibus_ack,
  input  logic        dbus_cyc,
  input  logic [13:0] dbus_adr,
  input  logic        dbus_we,
  input  logic [31:0] dbus_dat_i,
  input  logic [3:0]  dbus_sel,
  output logic [31:0] dbus_dat_o,
  output logic        dbus_ack,
  output logic        mem_cyc,
  output logic [13:0] mem_adr,
  output logic        mem_we,
  output logic [31:0] mem_dat_o,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;

  state_t state, state_nxt;
  logic   last_grant_d;  // 1: dbus was granted last
  logic   grant_i, grant_d;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (ibus_cyc && (!dbus_cyc || last_grant_d)) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (dbus_cyc) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      mem_cyc      <= 1'b0;
      mem_adr      <= '0;
      mem_we       <= 1'b0;
      mem_dat_o    <= '0;
      mem_sel      <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        mem_cyc      <= 1'b1;
        last_grant_d <= 1'b0;
        mem_adr      <= ibus_adr;
        mem_we       <= 1'b0;
        mem_dat_o    <= '0;
        mem_sel      <= 4'b1111;
      end else if (grant_d) begin
        mem_cyc      <= 1'b1;
        last_grant_d <= 1'b1;
        mem_adr      <= dbus_adr;
        mem_we       <= dbus_we;
        mem_dat_o    <= dbus_dat_i;
        mem_sel      <= dbus_sel;
      end else if ((state == BUSY_I || state == BUSY_D) && mem_ack) begin
        mem_cyc <= 1'b0;
      end
    end
  end

  // An ack is forwarded only if the requester is still waiting for it.
  assign ibus_ack   = mem_ack && (state == BUSY_I) && ibus_cyc;
  assign dbus_ack   = mem_ack && (state == BUSY_D) && dbus_cyc;
  assign ibus_dat_o = mem_dat_i;
  assign dbus_dat_o = mem_dat_i;

endmodule
